// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid data-bus transaction per load/store,
// load-data alignment/extension, pipeline stall and fault reporting.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_err_i,
    output logic [31:0] load_data_o,
    output logic        stall_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q, we_q, kill_q, fault_q;
    logic [1:0]    cause_q, off_q;
    logic [2:0]    funct3_q;
    logic [3:0]    be_q;
    logic [31:0]   addr_q, wdata_q, data_q;

    logic          op, size_ok, misaligned, idle_fault, accept, cnt_done, kill_now;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d, rdata_shift, load_aligned;

    always_comb begin
        op = mem_rd_i | mem_wr_i;
        case (funct3_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
            default:                                size_ok = 1'b0;
        endcase
        misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                     (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
        idle_fault = (state_q == StIdle) && op && !flush_i && (!size_ok || misaligned);
        accept     = (state_q == StIdle) && op && !flush_i && size_ok && !misaligned;

        be_d    = 4'b1111;
        wdata_d = wdata_i;
        if (mem_wr_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << addr_i[1:0];
                    wdata_d = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = wdata_i;
                end
            endcase
        end

        rdata_shift = dbus_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_aligned = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_aligned = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_aligned = {24'b0, rdata_shift[7:0]};
            3'b101:  load_aligned = {16'b0, rdata_shift[15:0]};
            default: load_aligned = rdata_shift;
        endcase

        cnt_done = (cnt_q == CW'(TIMEOUT - 1));
        // A flush arriving together with the response still kills it.
        kill_now = kill_q | flush_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            kill_q   <= 1'b0;
            fault_q  <= 1'b0;
            cause_q  <= 2'b00;
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            be_q     <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    fault_q <= 1'b0;
                    if (accept) begin
                        state_q  <= StReq;
                        req_q    <= 1'b1;
                        we_q     <= mem_wr_i;
                        addr_q   <= {addr_i[31:2], 2'b00};
                        be_q     <= be_d;
                        wdata_q  <= wdata_d;
                        funct3_q <= funct3_i;
                        off_q    <= addr_i[1:0];
                        cnt_q    <= '0;
                        kill_q   <= 1'b0;
                    end
                end
                StReq: begin
                    if (dbus_gnt_i) begin
                        // Once granted the bus owes us a response, so flush only kills it.
                        state_q <= StResp;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        kill_q  <= flush_i;
                    end else if (flush_i) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end else if (cnt_done) begin
                        state_q <= StDone;
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                        cause_q <= 2'b11;
                        data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StResp: begin
                    if (dbus_rvalid_i) begin
                        state_q <= StDone;
                        data_q  <= (we_q || kill_now) ? '0 : load_aligned;
                        fault_q <= dbus_err_i && !kill_now;
                        cause_q <= 2'b10;
                    end else if (cnt_done) begin
                        state_q <= StDone;
                        data_q  <= '0;
                        fault_q <= !kill_now;
                        cause_q <= 2'b11;
                    end else begin
                        cnt_q  <= cnt_q + CW'(1);
                        kill_q <= kill_now;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign dbus_req_o    = req_q;
    assign dbus_we_o     = we_q;
    assign dbus_addr_o   = addr_q;
    assign dbus_be_o     = be_q;
    assign dbus_wdata_o  = wdata_q;
    assign stall_o       = (state_q == StReq) || (state_q == StResp) || accept;
    assign fault_o       = idle_fault || (state_q == StDone && fault_q);
    assign fault_cause_o = idle_fault ? (size_ok ? 2'b01 : 2'b00) : cause_q;
    assign load_data_o   = (state_q == StDone) ? data_q : '0;
endmodule
